// File: rtl/debounce_bank.sv
// debounce_bank
//   Multi-channel input conditioner for buttons and switches. Every channel
//   runs its own synchroniser, optional polarity inversion, stability-count
//   debouncer, edge detector and (optionally) a hold-to-repeat pulse
//   generator, so downstream FSMs can consume clean, single-cycle events.
//
// Ports
//   clk_in      system clock
//   rst_in      asynchronous, active-high reset
//   noisy_in    [CHANNELS] raw pin levels, asynchronous to clk_in
//   clean_out   [CHANNELS] debounced logical level (1 = asserted)
//   rise_out    [CHANNELS] one-cycle pulse when clean_out goes 0->1
//   fall_out    [CHANNELS] one-cycle pulse when clean_out goes 1->0
//   repeat_out  [CHANNELS] one-cycle pulse on press, plus auto-repeat while held
module debounce_bank #(
  parameter int                  CHANNELS      = 5,
  parameter int                  NSYNC         = 3,
  parameter int                  STABLE_COUNT  = 1_000_000,
  parameter logic [CHANNELS-1:0] INVERT_MASK   = '0,
  parameter logic [CHANNELS-1:0] REPEAT_MASK   = '0,
  parameter int                  REPEAT_DELAY  = 50_000_000,
  parameter int                  REPEAT_PERIOD = 10_000_000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [CHANNELS-1:0] noisy_in,
  output logic [CHANNELS-1:0] clean_out,
  output logic [CHANNELS-1:0] rise_out,
  output logic [CHANNELS-1:0] fall_out,
  output logic [CHANNELS-1:0] repeat_out
);

  localparam int               CNT_W    = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [NSYNC-1:0] sync_q;
    logic             cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clean_q;
    logic             clean_d;
    logic             rise_q;
    logic             fall_q;
    logic             level_s;

    assign level_s = sync_q[NSYNC-1];

    // Synchroniser chain; active-low pins are inverted before the first flop
    // so everything downstream works in "1 = asserted" terms.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[NSYNC-2:0], noisy_in[i] ^ INVERT_MASK[i]};
      end
    end

    // The debounced level adopts the candidate only once the synchronised
    // level has matched it for STABLE_COUNT consecutive comparisons.
    always_comb begin
      clean_d = clean_q;
      if ((level_s == cand_q) && (cnt_q == CNT_LAST)) begin
        clean_d = cand_q;
      end
    end

    // Candidate/count tracking plus registered edge pulses. The counter
    // saturates so a long-held level never wraps into a false restart.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        cand_q  <= 1'b0;
        cnt_q   <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        if (level_s != cand_q) begin
          cand_q <= level_s;
          cnt_q  <= '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        clean_q <= clean_d;
        rise_q  <= clean_d & ~clean_q;
        fall_q  <= ~clean_d & clean_q;
      end
    end

    assign clean_out[i] = clean_q;
    assign rise_out[i]  = rise_q;
    assign fall_out[i]  = fall_q;

    if (REPEAT_MASK[i]) begin : g_rpt
      localparam int              RC_SPAN     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int              RC_W        = $clog2(RC_SPAN);
      localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
      localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);
      localparam logic [1:0]      ST_IDLE     = 2'd0;
      localparam logic [1:0]      ST_DELAY    = 2'd1;
      localparam logic [1:0]      ST_REPEAT   = 2'd2;

      logic [1:0]      state_q;
      logic [RC_W-1:0] rc_q;
      logic            rpt_q;

      // Hold-to-repeat FSM. A release always wins: the FSM drops to IDLE on
      // the same edge that raises fall_out, suppressing any pulse that was
      // due in that cycle.
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          state_q <= ST_IDLE;
          rc_q    <= '0;
          rpt_q   <= 1'b0;
        end else begin
          rpt_q <= 1'b0;
          if (~clean_d & clean_q) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
          end else begin
            case (state_q)
              ST_IDLE: begin
                if (clean_d & ~clean_q) begin
                  state_q <= ST_DELAY;
                  rc_q    <= '0;
                  rpt_q   <= 1'b1;
                end
              end
              ST_DELAY: begin
                if (rc_q == DELAY_LAST) begin
                  state_q <= ST_REPEAT;
                  rc_q    <= '0;
                  rpt_q   <= 1'b1;
                end else begin
                  rc_q <= rc_q + RC_W'(1);
                end
              end
              ST_REPEAT: begin
                if (rc_q == PERIOD_LAST) begin
                  rc_q  <= '0;
                  rpt_q <= 1'b1;
                end else begin
                  rc_q <= rc_q + RC_W'(1);
                end
              end
              default: begin
                state_q <= ST_IDLE;
                rc_q    <= '0;
              end
            endcase
          end
        end
      end

      assign repeat_out[i] = rpt_q;
    end else begin : g_norpt
      // Without auto-repeat the press pulse is simply the rise pulse.
      assign repeat_out[i] = rise_q;
    end
  end

endmodule
